// File: rtl/rotating_shift_register.sv
// Circular DEPTH x WIDTH register file preset to an arithmetic sequence, with
// forward/backward rotation, serial shift-in, random-access write/read and rotation tracking.
module rotating_shift_register #(
    parameter  int WIDTH     = 8,
    parameter  int DEPTH     = 10,
    parameter  int INIT_BASE = 5,
    parameter  int INIT_STEP = 5,
    localparam int IW        = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] ser_in,
    input  logic             wr_en,
    input  logic [IW-1:0]    wr_idx,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [IW-1:0]    rd_idx,
    output logic [WIDTH-1:0] rd_data,
    output logic [WIDTH-1:0] head,
    output logic [WIDTH-1:0] tail,
    output logic [IW-1:0]    rot_pos,
    output logic             wrap
);

    localparam logic [1:0]    MODE_FWD = 2'b01;
    localparam logic [1:0]    MODE_BWD = 2'b10;
    localparam logic [1:0]    MODE_SHF = 2'b11;
    localparam logic [IW:0]   DEPTH_L  = (IW+1)'(DEPTH);
    localparam logic [IW-1:0] LAST     = IW'(DEPTH - 1);

    logic [WIDTH-1:0] data     [DEPTH];
    logic [WIDTH-1:0] data_nxt [DEPTH];
    logic [IW-1:0]    pos_nxt;
    logic             wrap_nxt;

    function automatic logic [WIDTH-1:0] init_val(input int i);
        return WIDTH'(INIT_BASE + i * INIT_STEP);
    endfunction

    always_comb begin
        data_nxt = data;
        pos_nxt  = rot_pos;
        wrap_nxt = 1'b0;
        if (en) begin
            case (mode)
                MODE_FWD: begin
                    data_nxt[0] = data[DEPTH-1];
                    for (int i = 1; i < DEPTH; i++) data_nxt[i] = data[i-1];
                    wrap_nxt = (rot_pos == LAST);
                    pos_nxt  = wrap_nxt ? '0 : rot_pos + 1'b1;
                end
                MODE_BWD: begin
                    data_nxt[DEPTH-1] = data[0];
                    for (int i = 0; i < DEPTH-1; i++) data_nxt[i] = data[i+1];
                    wrap_nxt = (rot_pos == '0);
                    pos_nxt  = wrap_nxt ? LAST : rot_pos - 1'b1;
                end
                MODE_SHF: begin
                    data_nxt[0] = ser_in;
                    for (int i = 1; i < DEPTH; i++) data_nxt[i] = data[i-1];
                end
                default: ;
            endcase
        end
        // The random-access write lands on the post-shift array and wins at its stage.
        if (wr_en && ({1'b0, wr_idx} < DEPTH_L)) data_nxt[wr_idx] = wr_data;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) data[i] <= init_val(i);
            rot_pos <= '0;
            wrap    <= 1'b0;
        end else begin
            data    <= data_nxt;
            rot_pos <= pos_nxt;
            wrap    <= wrap_nxt;
        end
    end

    assign rd_data = ({1'b0, rd_idx} < DEPTH_L) ? data[rd_idx] : '0;
    assign head    = data[0];
    assign tail    = data[DEPTH-1];

endmodule

// File: tb/tb_rotating_shift_register.sv
// Self-checking bench for rotating_shift_register (WIDTH=8, DEPTH=10 defaults):
// directed table, corner sequences, and randomized traffic against a ring model.
`timescale 1ns/1ps
module tb_rotating_shift_register;

    localparam int W = 8;
    localparam int D = 10;
    localparam int IW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          en;
    logic [1:0]    mode;
    logic [W-1:0]  ser_in;
    logic          wr_en;
    logic [IW-1:0] wr_idx;
    logic [W-1:0]  wr_data;
    logic [IW-1:0] rd_idx;
    logic [W-1:0]  rd_data;
    logic [W-1:0]  head;
    logic [W-1:0]  tail;
    logic [IW-1:0] rot_pos;
    logic          wrap;

    rotating_shift_register dut (
        .clk(clk), .reset(reset), .en(en), .mode(mode), .ser_in(ser_in),
        .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data), .rd_idx(rd_idx),
        .rd_data(rd_data), .head(head), .tail(tail), .rot_pos(rot_pos), .wrap(wrap)
    );

    always #50 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference: ring contents as plain ints, net rotation count as an integer.
    int m [D];
    int net_rot;
    int m_wrap;

    function automatic int mod_d(input int v);
        return ((v % D) + D) % D;
    endfunction

    task automatic model_step(input logic rn, input logic e, input logic [1:0] md,
                              input logic [W-1:0] s, input logic we,
                              input logic [IW-1:0] wi, input logic [W-1:0] wd);
        int t [D];
        if (!rn) begin
            for (int i = 0; i < D; i++) m[i] = (5 + 5 * i) % 256;
            net_rot = 0;
            m_wrap  = 0;
        end else begin
            t = m;
            m_wrap = 0;
            if (e && md == 2'b01) begin
                for (int i = 0; i < D; i++) t[i] = m[mod_d(i - 1)];
                if (mod_d(net_rot) == D - 1) m_wrap = 1;
                net_rot = net_rot + 1;
            end else if (e && md == 2'b10) begin
                for (int i = 0; i < D; i++) t[i] = m[mod_d(i + 1)];
                if (mod_d(net_rot) == 0) m_wrap = 1;
                net_rot = net_rot - 1;
            end else if (e && md == 2'b11) begin
                t[0] = int'(s);
                for (int i = 1; i < D; i++) t[i] = m[i-1];
            end
            if (we && int'(wi) < D) t[wi] = int'(wd);
            m = t;
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc(input logic rn, input logic e, input logic [1:0] md,
                       input logic [W-1:0] s, input logic we,
                       input logic [IW-1:0] wi, input logic [W-1:0] wd);
        reset = rn; en = e; mode = md; ser_in = s;
        wr_en = we; wr_idx = wi; wr_data = wd;
        @(posedge clk);
        model_step(rn, e, md, s, we, wi, wd);
        #1;
    endtask

    task automatic check_model(input string tag);
        chk({tag, " head"}, int'(head), m[0]);
        chk({tag, " tail"}, int'(tail), m[D-1]);
        chk({tag, " rot_pos"}, int'(rot_pos), mod_d(net_rot));
        chk({tag, " wrap"}, int'(wrap), m_wrap);
        for (int i = 0; i < 16; i++) begin
            rd_idx = IW'(i);
            #1;
            chk($sformatf("%s rd[%0d]", tag, i), int'(rd_data), (i < D) ? m[i] : 0);
        end
    endtask

    task automatic rd_chk(input string name, input int idx, input int exp);
        rd_idx = IW'(idx);
        #1;
        chk(name, int'(rd_data), exp);
    endtask

    typedef struct {
        logic          e;
        logic [1:0]    md;
        logic [W-1:0]  s;
        logic          we;
        logic [IW-1:0] wi;
        logic [W-1:0]  wd;
        int            x_head;
        int            x_tail;
        int            x_pos;
        int            x_wrap;
    } vec_t;

    vec_t vecs [10];

    initial begin
        vecs[0] = '{1'b1, 2'b01, 8'h00, 1'b0, 4'd0,  8'h00, 50,  45,  1, 0};
        vecs[1] = '{1'b1, 2'b10, 8'h00, 1'b0, 4'd0,  8'h00, 5,   50,  0, 0};
        vecs[2] = '{1'b1, 2'b10, 8'h00, 1'b0, 4'd0,  8'h00, 10,  5,   9, 1};
        vecs[3] = '{1'b1, 2'b00, 8'h00, 1'b0, 4'd0,  8'h00, 10,  5,   9, 0};
        vecs[4] = '{1'b0, 2'b01, 8'h00, 1'b0, 4'd0,  8'h00, 10,  5,   9, 0};
        vecs[5] = '{1'b1, 2'b01, 8'h00, 1'b0, 4'd0,  8'h00, 5,   50,  0, 1};
        vecs[6] = '{1'b1, 2'b11, 8'hAA, 1'b0, 4'd0,  8'h00, 170, 45,  0, 0};
        vecs[7] = '{1'b1, 2'b01, 8'h00, 1'b1, 4'd0,  8'h11, 17,  40,  1, 0};
        vecs[8] = '{1'b0, 2'b01, 8'h00, 1'b1, 4'd9,  8'h99, 17,  153, 1, 0};
        vecs[9] = '{1'b0, 2'b00, 8'h00, 1'b1, 4'd12, 8'hEE, 17,  153, 1, 0};

        reset = 1'b0; en = 1'b0; mode = 2'b00; ser_in = '0;
        wr_en = 1'b0; wr_idx = '0; wr_data = '0; rd_idx = '0;

        // Reset state
        cyc(1'b0, 1'b0, 2'b00, 8'h00, 1'b0, 4'd0, 8'h00);
        for (int i = 0; i < 16; i++) rd_chk($sformatf("reset rd[%0d]", i), i, (i < D) ? 5 * (i + 1) : 0);
        chk("reset rot_pos", int'(rot_pos), 0);
        chk("reset wrap", int'(wrap), 0);

        // Directed table
        for (int k = 0; k < 10; k++) begin
            cyc(1'b1, vecs[k].e, vecs[k].md, vecs[k].s, vecs[k].we, vecs[k].wi, vecs[k].wd);
            chk($sformatf("vec%0d head", k), int'(head), vecs[k].x_head);
            chk($sformatf("vec%0d tail", k), int'(tail), vecs[k].x_tail);
            chk($sformatf("vec%0d rot_pos", k), int'(rot_pos), vecs[k].x_pos);
            chk($sformatf("vec%0d wrap", k), int'(wrap), vecs[k].x_wrap);
        end
        rd_chk("vec shift rd[2]", 2, 5);
        rd_chk("vec ignored-write rd[1]", 1, 170);

        // Ten forward rotations return to the preset with a single wrap pulse
        cyc(1'b0, 1'b0, 2'b00, 8'h00, 1'b0, 4'd0, 8'h00);
        for (int k = 0; k < 10; k++) begin
            cyc(1'b1, 1'b1, 2'b01, 8'h00, 1'b0, 4'd0, 8'h00);
            chk($sformatf("fwd10 wrap@%0d", k + 1), int'(wrap), (k == 9) ? 1 : 0);
        end
        for (int i = 0; i < D; i++) rd_chk($sformatf("fwd10 rd[%0d]", i), i, 5 * (i + 1));
        chk("fwd10 rot_pos", int'(rot_pos), 0);
        cyc(1'b1, 1'b1, 2'b00, 8'h00, 1'b0, 4'd0, 8'h00);
        chk("fwd10 wrap drops", int'(wrap), 0);

        // Write overrides the shifted value at its stage
        cyc(1'b0, 1'b0, 2'b00, 8'h00, 1'b0, 4'd0, 8'h00);
        cyc(1'b1, 1'b1, 2'b01, 8'h00, 1'b1, 4'd3, 8'h77);
        rd_chk("fwd+wr rd[3]", 3, 8'h77);
        rd_chk("fwd+wr rd[4]", 4, 20);
        check_model("fwd+wr");
        cyc(1'b1, 1'b0, 2'b01, 8'h00, 1'b1, 4'd3, 8'h3C);
        rd_chk("hold+wr rd[3]", 3, 8'h3C);
        check_model("hold+wr");
        cyc(1'b1, 1'b1, 2'b01, 8'h00, 1'b1, 4'd12, 8'hEE);
        check_model("fwd+wr12");

        // Reset dominates enable and write mid-rotation
        cyc(1'b1, 1'b1, 2'b10, 8'h00, 1'b0, 4'd0, 8'h00);
        cyc(1'b0, 1'b1, 2'b01, 8'h00, 1'b1, 4'd2, 8'hFF);
        for (int i = 0; i < D; i++) rd_chk($sformatf("rst-dom rd[%0d]", i), i, 5 * (i + 1));
        chk("rst-dom rot_pos", int'(rot_pos), 0);
        chk("rst-dom wrap", int'(wrap), 0);

        // Randomized traffic against the ring model
        for (int k = 0; k < 300; k++) begin
            cyc(($urandom_range(0, 31) != 0), ($urandom_range(0, 7) != 0),
                2'($urandom_range(0, 3)), 8'($urandom), ($urandom_range(0, 3) == 0),
                4'($urandom_range(0, 15)), 8'($urandom));
            check_model($sformatf("rand%0d", k));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
